// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce signal generator: FSM states,
// LFSR polynomial/seed and the Galois LFSR step function.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never maps to zero.
  function automatic logic [15:0] lfsrStep(input logic [15:0] state);
    lfsrStep = state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
  endfunction

endpackage

// File: rtl/bounce_signal_generator_if.sv
// Request/response bundle of the bounce signal generator. The optional
// edge_count output exists only when BOUNCE_GEN_EDGE_COUNT_EN is defined.
interface bounce_signal_generator_if;

  logic press_req;
  logic bounce_out;
  logic busy;
  logic settled;
  logic tick_out;
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
  logic [7:0] edge_count;

  modport master (output press_req,
                  input  bounce_out, busy, settled, tick_out, edge_count);
  modport slave  (input  press_req,
                  output bounce_out, busy, settled, tick_out, edge_count);
`else
  modport master (output press_req,
                  input  bounce_out, busy, settled, tick_out);
  modport slave  (input  press_req,
                  output bounce_out, busy, settled, tick_out);
`endif

endinterface

// File: rtl/tick_prescaler.sv
// Free-running tick divider: tick is high for one cycle every PRESCALE_MAX+1
// cycles; clear restarts the period from zero.
module tick_prescaler #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int PRESCALE_MAX   = 49999
) (
  input  logic clock50M,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESCALE_WIDTH-1:0] COUNT_MAX = PRESCALE_WIDTH'(PRESCALE_MAX);
  localparam logic [PRESCALE_WIDTH-1:0] COUNT_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] count_q;

  assign tick = (count_q == COUNT_MAX);

  // Clear wins over the wrap so a restarted period is always a full one.
  always_ff @(posedge clock50M or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + COUNT_ONE;
    end
  end

endmodule

// File: rtl/bounce_signal_generator.sv
// Turns a clean request level into a bouncy signal: a burst of LFSR samples
// per request edge, then the settled level. BOUNCE_GEN_EDGE_COUNT_EN adds edge_count.
module bounce_signal_generator
  import bounce_gen_pkg::*;
#(
  parameter int          PRESCALE_MAX   = 49999,
  parameter int          PRESCALE_WIDTH = 16,
  parameter int          BOUNCE_TICKS   = 20,
  parameter int          SETTLE_TICKS   = 10,
  parameter int          CNT_WIDTH      = 8,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEFAULT
) (
  input  logic                      clock50M,
  input  logic                      reset_n,
  bounce_signal_generator_if.slave  genIf
);

  localparam logic [15:0]          SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_WIDTH-1:0] BOUNCE_LOAD = CNT_WIDTH'(BOUNCE_TICKS);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_TICKS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic                 sync1_q, pressS_q;
  state_e               state_q, state_d;
  logic                 target_q, target_d;
  logic                 bounceOut_q, bounceOut_d;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
  logic [15:0]          lfsr_q, lfsr_d, lfsrNext;
  logic                 busy_q, settled_q;
  logic                 tick;
  logic                 retarget;

  // A new request level restarts the burst from any state, including IDLE.
  assign retarget = (pressS_q != target_q);
  assign lfsrNext = lfsrStep(lfsr_q);

  tick_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .PRESCALE_MAX   (PRESCALE_MAX)
  ) uPrescaler (
    .clock50M (clock50M),
    .reset_n  (reset_n),
    .clear    (retarget),
    .tick     (tick)
  );

  always_ff @(posedge clock50M or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      pressS_q <= 1'b0;
    end else begin
      sync1_q  <= genIf.press_req;
      pressS_q <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    bounceOut_d = bounceOut_q;
    bcnt_d      = bcnt_q;
    scnt_d      = scnt_q;
    lfsr_d      = lfsr_q;
    if (retarget) begin
      target_d = pressS_q;
      bcnt_d   = BOUNCE_LOAD;
      state_d  = BOUNCE;
    end else begin
      case (state_q)
        BOUNCE: begin
          if (tick) begin
            if (bcnt_q != '0) begin
              lfsr_d      = lfsrNext;
              bounceOut_d = lfsrNext[0];
              bcnt_d      = bcnt_q - CNT_ONE;
            end else begin
              bounceOut_d = target_q;
              scnt_d      = SETTLE_LOAD;
              state_d     = SETTLE;
            end
          end
        end
        SETTLE: begin
          if (tick) begin
            if (scnt_q != '0) begin
              scnt_d = scnt_q - CNT_ONE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // busy/settled decode the next state so they change on the same edge as the state.
  always_ff @(posedge clock50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      target_q    <= 1'b0;
      bounceOut_q <= 1'b0;
      bcnt_q      <= '0;
      scnt_q      <= '0;
      lfsr_q      <= SEED_EFF;
      busy_q      <= 1'b0;
      settled_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      bounceOut_q <= bounceOut_d;
      bcnt_q      <= bcnt_d;
      scnt_q      <= scnt_d;
      lfsr_q      <= lfsr_d;
      busy_q      <= (state_d != IDLE);
      settled_q   <= (state_d == IDLE);
    end
  end

  assign genIf.bounce_out = bounceOut_q;
  assign genIf.busy       = busy_q;
  assign genIf.settled    = settled_q;
  assign genIf.tick_out   = tick;

`ifdef BOUNCE_GEN_EDGE_COUNT_EN
  logic [7:0] edgeCount_q;

  // Restarts only on a fresh event from IDLE; retargets keep accumulating.
  always_ff @(posedge clock50M or negedge reset_n) begin
    if (!reset_n) begin
      edgeCount_q <= 8'd0;
    end else if ((state_q == IDLE) && (state_d == BOUNCE)) begin
      edgeCount_q <= 8'd0;
    end else if ((bounceOut_d != bounceOut_q) && (edgeCount_q != 8'hFF)) begin
      edgeCount_q <= edgeCount_q + 8'd1;
    end
  end

  assign genIf.edge_count = edgeCount_q;
`endif

endmodule

// File: tb/tb_bounce_signal_generator.sv
// Self-checking bench for bounce_signal_generator: event-schedule reference
// model compared every cycle, plus hand-computed literal checks per scenario.
module tb_bounce_signal_generator;

  localparam int PERIOD  = 4;
  localparam int NBOUNCE = 5;
  localparam int NSETTLE = 3;

  logic clock50M = 1'b0;
  logic reset_n  = 1'b0;

  always #10 clock50M = ~clock50M;

  bounce_signal_generator_if ifMain ();
  bounce_signal_generator_if ifZero ();

  bounce_signal_generator #(
    .PRESCALE_MAX   (3),
    .PRESCALE_WIDTH (16),
    .BOUNCE_TICKS   (NBOUNCE),
    .SETTLE_TICKS   (NSETTLE),
    .CNT_WIDTH      (8),
    .LFSR_SEED      (16'hACE1)
  ) dutMain (
    .clock50M (clock50M),
    .reset_n  (reset_n),
    .genIf    (ifMain)
  );

  bounce_signal_generator #(
    .PRESCALE_MAX   (3),
    .PRESCALE_WIDTH (16),
    .BOUNCE_TICKS   (0),
    .SETTLE_TICKS   (NSETTLE),
    .CNT_WIDTH      (8),
    .LFSR_SEED      (16'hACE1)
  ) dutZero (
    .clock50M (clock50M),
    .reset_n  (reset_n),
    .genIf    (ifZero)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit running     = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic mainLevel, input logic zeroLevel);
    ifMain.press_req = mainLevel;
    ifZero.press_req = zeroLevel;
  endtask

  function automatic logic [15:0] stepLfsr(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference model: an event is a schedule of tick slots counted from its start edge.
  int          cyc       = 0;
  int          eventEdge = 0;
  int          tickBase  = 0;
  logic        hist0     = 1'b0;
  logic        hist1     = 1'b0;
  logic        mTarget   = 1'b0;
  logic        mBounce   = 1'b0;
  logic        mActive   = 1'b0;
  logic [15:0] mLfsr     = 16'hACE1;
  int          mEdges    = 0;

  always @(posedge clock50M or negedge reset_n) begin
    logic seen;
    logic newBounce;
    int   age;
    int   slot;
    if (!reset_n) begin
      cyc = 0; eventEdge = 0; tickBase = 0;
      hist0 = 1'b0; hist1 = 1'b0;
      mTarget = 1'b0; mBounce = 1'b0; mActive = 1'b0;
      mLfsr = 16'hACE1; mEdges = 0;
    end else begin
      cyc++;
      seen  = hist1;
      hist1 = hist0;
      hist0 = ifMain.press_req;
      newBounce = mBounce;
      if (seen != mTarget) begin
        if (!mActive) mEdges = 0;
        mTarget   = seen;
        mActive   = 1'b1;
        eventEdge = cyc;
        tickBase  = cyc;
      end else if (mActive) begin
        age = cyc - eventEdge;
        if (age % PERIOD == 0) begin
          slot = age / PERIOD;
          if (slot <= NBOUNCE) begin
            mLfsr     = stepLfsr(mLfsr);
            newBounce = mLfsr[0];
          end else if (slot == NBOUNCE + 1) begin
            newBounce = mTarget;
          end else if (slot == NBOUNCE + NSETTLE + 2) begin
            mActive = 1'b0;
          end
        end
      end
      if (newBounce != mBounce && mEdges < 255) mEdges++;
      mBounce = newBounce;
    end
  end

  always @(negedge clock50M) begin
    if (running) begin
      checkOutput("bounce_out", ifMain.bounce_out, mBounce);
      checkOutput("busy",       ifMain.busy,       mActive);
      checkOutput("settled",    ifMain.settled,    !mActive);
      checkOutput("tick_out",   ifMain.tick_out,   ((cyc - tickBase) % PERIOD) == PERIOD - 1);
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
      checkOutput("edge_count", ifMain.edge_count, mEdges);
`endif
    end
  end

  initial begin
    int changes;
    logic lastBounce;

    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clock50M);
    reset_n = 1'b1;
    repeat (2) @(negedge clock50M);
    checkOutput("resetBounce",  ifMain.bounce_out, 1'b0);
    checkOutput("resetBusy",    ifMain.busy,       1'b0);
    checkOutput("resetSettled", ifMain.settled,    1'b1);

    // Reset in the middle of a burst, right after the 1 sample at edge 23.
    applyStimulus(1'b1, 1'b0);
    repeat (25) @(negedge clock50M);
    checkOutput("preResetBounce", ifMain.bounce_out, 1'b1);
    checkOutput("preResetBusy",   ifMain.busy,       1'b1);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midResetBounce",  ifMain.bounce_out, 1'b0);
    checkOutput("midResetBusy",    ifMain.busy,       1'b0);
    checkOutput("midResetSettled", ifMain.settled,    1'b1);
    @(negedge clock50M);
    applyStimulus(1'b0, 1'b0);
    reset_n = 1'b1;
    changes = 0;
    lastBounce = ifMain.bounce_out;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock50M);
      if (ifMain.bounce_out !== lastBounce) changes++;
      lastBounce = ifMain.bounce_out;
    end
    checkOutput("quietAfterReset", changes, 0);

    // Press from the seed: samples 0,0,0,0,1 then target 1.
    applyStimulus(1'b1, 1'b1);
    for (int k = 1; k <= 43; k++) begin
      @(negedge clock50M);
      if (k == 2)  checkOutput("pressBusyEdge2",  ifMain.busy, 1'b0);
      if (k == 3)  checkOutput("pressBusyEdge3",  ifMain.busy, 1'b1);
      if (k == 6)  checkOutput("zeroBounceEdge6", ifZero.bounce_out, 1'b0);
      if (k == 7)  checkOutput("zeroBounceEdge7", ifZero.bounce_out, 1'b1);
      if (k == 22) checkOutput("pressSample4",    ifMain.bounce_out, 1'b0);
      if (k == 23) checkOutput("pressSample5",    ifMain.bounce_out, 1'b1);
      if (k == 27) checkOutput("pressTarget",     ifMain.bounce_out, 1'b1);
      if (k == 42) checkOutput("pressSettled42",  ifMain.settled, 1'b0);
      if (k == 43) checkOutput("pressSettled43",  ifMain.settled, 1'b1);
    end
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    checkOutput("pressEdgeCount", ifMain.edge_count, 8'd1);
`endif
    repeat (5) @(negedge clock50M);

    // Release continues the LFSR: samples 1,1,0,0,1 then target 0.
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 43; k++) begin
      @(negedge clock50M);
      if (k == 7)  checkOutput("releaseSample1",   ifMain.bounce_out, 1'b1);
      if (k == 15) checkOutput("releaseSample3",   ifMain.bounce_out, 1'b0);
      if (k == 23) checkOutput("releaseSample5",   ifMain.bounce_out, 1'b1);
      if (k == 27) checkOutput("releaseTarget",    ifMain.bounce_out, 1'b0);
      if (k == 43) checkOutput("releaseSettled",   ifMain.settled, 1'b1);
    end
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    checkOutput("releaseEdgeCount", ifMain.edge_count, 8'd3);
`endif
    repeat (5) @(negedge clock50M);

    // Retarget at edge 16, mid third sample; new samples 1,1,0,1,0 on ticks 20..36.
    applyStimulus(1'b1, 1'b1);
    for (int k = 1; k <= 56; k++) begin
      @(negedge clock50M);
      if (k == 13) applyStimulus(1'b0, 1'b1);
      if (k == 16) checkOutput("retargetBusy",    ifMain.busy, 1'b1);
      if (k == 19) checkOutput("retargetHold",    ifMain.bounce_out, 1'b0);
      if (k == 20) checkOutput("retargetSample1", ifMain.bounce_out, 1'b1);
      if (k == 35) checkOutput("retargetSample4", ifMain.bounce_out, 1'b1);
      if (k == 40) checkOutput("retargetTarget",  ifMain.bounce_out, 1'b0);
      if (k == 55) checkOutput("retargetBusy55",  ifMain.settled, 1'b0);
      if (k == 56) checkOutput("retargetSettled", ifMain.settled, 1'b1);
    end
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    checkOutput("retargetEdgeCount", ifMain.edge_count, 8'd4);
`endif
    repeat (10) @(negedge clock50M);

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
